mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arb.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Memory arbiter: serialises fetch, load and store onto a single
// memory-controller port, with one transaction outstanding and fetch anti-starvation.
module mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int AGE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_add,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_dat,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_add,
    input  logic [2:0]        ld_len,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_dat,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_add,
    input  logic [2:0]        st_len,
    input  logic [DATA_W-1:0] st_dat,
    output logic              st_gnt,
    output logic              st_done,
    input  logic              io_full,
    output logic              mc_en,
    output logic              mc_rw,
    output logic [2:0]        mc_len,
    output logic [ADDR_W-1:0] mc_add,
    output logic [DATA_W-1:0] mc_dat,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdat
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} own_t;

    localparam logic [3:0] AGE_TOP = 4'(AGE_MAX);

    state_t state_q, state_d;
    own_t   own_q, own_d;
    logic [3:0] age_q, age_d;
    logic cancel_q, cancel_d;
    logic if_gnt_q, if_gnt_d, ld_gnt_q, ld_gnt_d, st_gnt_q, st_gnt_d;
    logic if_done_q, if_done_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
    logic mc_en_q, mc_en_d, mc_rw_q, mc_rw_d;
    logic [2:0] mc_len_q, mc_len_d;
    logic [ADDR_W-1:0] mc_add_q, mc_add_d;
    logic [DATA_W-1:0] mc_dat_q, mc_dat_d;
    logic [DATA_W-1:0] if_dat_q, if_dat_d, ld_dat_q, ld_dat_d;

    logic st_el, ld_el, if_el, if_win;
    logic [3:0] age_inc;

    // I/O-mapped stores stall only while the output buffer is full
    assign st_el   = st_req && !((st_add[17:16] == 2'b11) && io_full);
    assign ld_el   = ld_req;
    assign if_el   = if_req && !clr;
    assign if_win  = if_el && ((age_q == AGE_TOP) || (!st_el && !ld_el));
    assign age_inc = if_el ? ((age_q >= AGE_TOP) ? AGE_TOP : age_q + 4'd1)
                           : age_q;

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        age_d     = age_q;
        cancel_d  = cancel_q;
        if_gnt_d  = if_gnt_q;
        ld_gnt_d  = ld_gnt_q;
        st_gnt_d  = st_gnt_q;
        if_done_d = if_done_q;
        ld_done_d = ld_done_q;
        st_done_d = st_done_q;
        mc_en_d   = mc_en_q;
        mc_rw_d   = mc_rw_q;
        mc_len_d  = mc_len_q;
        mc_add_d  = mc_add_q;
        mc_dat_d  = mc_dat_q;
        if_dat_d  = if_dat_q;
        ld_dat_d  = ld_dat_q;
        if (en) begin
            if_gnt_d  = 1'b0;
            ld_gnt_d  = 1'b0;
            st_gnt_d  = 1'b0;
            if_done_d = 1'b0;
            ld_done_d = 1'b0;
            st_done_d = 1'b0;
            mc_en_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (if_win) begin
                        if_gnt_d = 1'b1;
                        mc_en_d  = 1'b1;
                        mc_rw_d  = 1'b0;
                        mc_len_d = 3'd4;
                        mc_add_d = if_add;
                        own_d    = OWN_IF;
                        age_d    = 4'd0;
                        state_d  = BUSY;
                    end else if (st_el) begin
                        st_gnt_d = 1'b1;
                        mc_en_d  = 1'b1;
                        mc_rw_d  = 1'b1;
                        mc_len_d = st_len;
                        mc_add_d = st_add;
                        mc_dat_d = st_dat;
                        own_d    = OWN_ST;
                        age_d    = age_inc;
                        state_d  = BUSY;
                    end else if (ld_el) begin
                        ld_gnt_d = 1'b1;
                        mc_en_d  = 1'b1;
                        mc_rw_d  = 1'b0;
                        mc_len_d = ld_len;
                        mc_add_d = ld_add;
                        own_d    = OWN_LD;
                        age_d    = age_inc;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    if (clr) cancel_d = 1'b1;
                    if (mc_done) begin
                        state_d  = GAP;
                        cancel_d = 1'b0;
                        unique case (own_q)
                            OWN_IF: begin
                                if (!cancel_q && !clr) begin
                                    if_done_d = 1'b1;
                                    if_dat_d  = mc_rdat;
                                end
                            end
                            OWN_LD: begin
                                ld_done_d = 1'b1;
                                ld_dat_d  = mc_rdat;
                            end
                            OWN_ST: st_done_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
                GAP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_q     <= OWN_IF;
            age_q     <= 4'd0;
            cancel_q  <= 1'b0;
            if_gnt_q  <= 1'b0;
            ld_gnt_q  <= 1'b0;
            st_gnt_q  <= 1'b0;
            if_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            mc_en_q   <= 1'b0;
            mc_rw_q   <= 1'b0;
            mc_len_q  <= 3'd0;
            mc_add_q  <= '0;
            mc_dat_q  <= '0;
            if_dat_q  <= '0;
            ld_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            age_q     <= age_d;
            cancel_q  <= cancel_d;
            if_gnt_q  <= if_gnt_d;
            ld_gnt_q  <= ld_gnt_d;
            st_gnt_q  <= st_gnt_d;
            if_done_q <= if_done_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
            mc_en_q   <= mc_en_d;
            mc_rw_q   <= mc_rw_d;
            mc_len_q  <= mc_len_d;
            mc_add_q  <= mc_add_d;
            mc_dat_q  <= mc_dat_d;
            if_dat_q  <= if_dat_d;
            ld_dat_q  <= ld_dat_d;
        end
    end

    assign if_gnt  = if_gnt_q;
    assign ld_gnt  = ld_gnt_q;
    assign st_gnt  = st_gnt_q;
    assign if_done = if_done_q;
    assign ld_done = ld_done_q;
    assign st_done = st_done_q;
    assign if_dat  = if_dat_q;
    assign ld_dat  = ld_dat_q;
    assign mc_en   = mc_en_q;
    assign mc_rw   = mc_rw_q;
    assign mc_len  = mc_len_q;
    assign mc_add  = mc_add_q;
    assign mc_dat  = mc_dat_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus a randomised
// run against a transaction-level arbitration model.
module tb_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int AM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, clr, io_full, mc_done;
    logic if_req, ld_req, st_req;
    logic [AW-1:0] if_add, ld_add, st_add;
    logic [2:0] ld_len, st_len;
    logic [DW-1:0] st_dat, mc_rdat;
    logic if_gnt, if_done, ld_gnt, ld_done, st_gnt, st_done;
    logic [DW-1:0] if_dat, ld_dat, mc_dat;
    logic mc_en, mc_rw;
    logic [2:0] mc_len;
    logic [AW-1:0] mc_add;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arb #(.ADDR_W(AW), .DATA_W(DW), .AGE_MAX(AM)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .if_req(if_req), .if_add(if_add), .if_gnt(if_gnt),
        .if_done(if_done), .if_dat(if_dat),
        .ld_req(ld_req), .ld_add(ld_add), .ld_len(ld_len),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_dat(ld_dat),
        .st_req(st_req), .st_add(st_add), .st_len(st_len),
        .st_dat(st_dat), .st_gnt(st_gnt), .st_done(st_done),
        .io_full(io_full), .mc_en(mc_en), .mc_rw(mc_rw),
        .mc_len(mc_len), .mc_add(mc_add), .mc_dat(mc_dat),
        .mc_done(mc_done), .mc_rdat(mc_rdat)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic complete(input logic [DW-1:0] d);
        mc_done = 1'b1;
        mc_rdat = d;
        tick();
        mc_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({if_gnt, ld_gnt, st_gnt, if_done, ld_done, st_done, mc_en, mc_rw} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_pulses got %b want 0",
                {if_gnt, ld_gnt, st_gnt, if_done, ld_done, st_done, mc_en, mc_rw});
        end
        n_cmp++;
        if ({mc_len, mc_add, mc_dat, if_dat, ld_dat} !== '0) begin
            n_bad++;
            $display("FAIL reset_fields got len=%0d add=%h dat=%h", mc_len, mc_add, mc_dat);
        end
        rst = 1'b0;
        complete(32'hDEAD0001);
        n_cmp++;
        if ({if_done, ld_done, st_done, mc_en} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_mc_done got %b want 0000", {if_done, ld_done, st_done, mc_en});
        end
    endtask

    task automatic test_fetch;
        if_add = 32'h1000;
        if_req = 1'b1;
        tick();
        n_cmp++;
        if ({if_gnt, mc_en, mc_rw} !== 3'b110) begin
            n_bad++;
            $display("FAIL fetch_gnt got gnt/en/rw=%b want 110", {if_gnt, mc_en, mc_rw});
        end
        n_cmp++;
        if (mc_len !== 3'd4 || mc_add !== 32'h1000) begin
            n_bad++;
            $display("FAIL fetch_cmd got len=%0d add=%h want 4 1000", mc_len, mc_add);
        end
        tick();
        n_cmp++;
        if ({if_gnt, mc_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL fetch_pulse got %b want 00", {if_gnt, mc_en});
        end
        tick();
        ld_req = 1'b1;
        ld_add = 32'h80;
        ld_len = 3'd1;
        complete(32'h00A00093);
        n_cmp++;
        if (if_done !== 1'b1 || if_dat !== 32'h00A00093) begin
            n_bad++;
            $display("FAIL fetch_done got done=%b dat=%h want 1 00a00093", if_done, if_dat);
        end
        n_cmp++;
        if (ld_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL done_no_gnt got %b want 0", ld_gnt);
        end
        if_req = 1'b0;
        tick();
        n_cmp++;
        if ({if_done, ld_gnt} !== 2'b00) begin
            n_bad++;
            $display("FAIL gap_no_gnt got %b want 00", {if_done, ld_gnt});
        end
        tick();
        n_cmp++;
        if (ld_gnt !== 1'b1 || mc_len !== 3'd1 || mc_add !== 32'h80) begin
            n_bad++;
            $display("FAIL load_after_gap got gnt=%b len=%0d add=%h", ld_gnt, mc_len, mc_add);
        end
        complete(32'h11223344);
        n_cmp++;
        if (ld_done !== 1'b1 || ld_dat !== 32'h11223344) begin
            n_bad++;
            $display("FAIL load_done got done=%b dat=%h want 1 11223344", ld_done, ld_dat);
        end
        ld_req = 1'b0;
        tick();
    endtask

    task automatic test_io_block;
        st_req = 1'b1;
        st_add = 32'h30000;
        st_len = 3'd4;
        st_dat = 32'hCAFEF00D;
        io_full = 1'b1;
        ld_req = 1'b1;
        ld_add = 32'h204;
        ld_len = 3'd2;
        tick();
        n_cmp++;
        if ({ld_gnt, st_gnt, mc_rw} !== 3'b100 || mc_len !== 3'd2) begin
            n_bad++;
            $display("FAIL io_load_first got ld/st/rw=%b len=%0d", {ld_gnt, st_gnt, mc_rw}, mc_len);
        end
        complete(32'h0000BEEF);
        n_cmp++;
        if (ld_done !== 1'b1 || ld_dat !== 32'h0000BEEF) begin
            n_bad++;
            $display("FAIL io_load_done got done=%b dat=%h", ld_done, ld_dat);
        end
        ld_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({st_gnt, mc_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL io_blocked got %b want 00", {st_gnt, mc_en});
        end
        io_full = 1'b0;
        tick();
        n_cmp++;
        if ({st_gnt, mc_rw} !== 2'b11 || mc_len !== 3'd4 || mc_add !== 32'h30000
            || mc_dat !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL io_store got gnt/rw=%b len=%0d add=%h dat=%h",
                {st_gnt, mc_rw}, mc_len, mc_add, mc_dat);
        end
        complete(32'hFFFFFFFF);
        n_cmp++;
        if (st_done !== 1'b1 || ld_dat !== 32'h0000BEEF) begin
            n_bad++;
            $display("FAIL io_store_done got done=%b ld_dat=%h", st_done, ld_dat);
        end
        st_req = 1'b0;
        tick();
    endtask

    task automatic test_clr;
        if_req = 1'b1;
        if_add = 32'h2000;
        clr = 1'b1;
        tick();
        n_cmp++;
        if ({if_gnt, mc_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL clr_at_grant got %b want 00", {if_gnt, mc_en});
        end
        clr = 1'b0;
        tick();
        n_cmp++;
        if (if_gnt !== 1'b1 || mc_add !== 32'h2000) begin
            n_bad++;
            $display("FAIL clr_regrant got gnt=%b add=%h", if_gnt, mc_add);
        end
        clr = 1'b1;
        if_req = 1'b0;
        tick();
        clr = 1'b0;
        tick();
        complete(32'h00000099);
        n_cmp++;
        if (if_done !== 1'b0 || if_dat !== 32'h00A00093) begin
            n_bad++;
            $display("FAIL clr_suppress got done=%b dat=%h want 0 00a00093", if_done, if_dat);
        end
        tick();
        if_req = 1'b1;
        if_add = 32'h3000;
        tick();
        n_cmp++;
        if (if_gnt !== 1'b1 || mc_add !== 32'h3000) begin
            n_bad++;
            $display("FAIL clr_next_gnt got gnt=%b add=%h", if_gnt, mc_add);
        end
        complete(32'h12345678);
        n_cmp++;
        if (if_done !== 1'b1 || if_dat !== 32'h12345678) begin
            n_bad++;
            $display("FAIL clr_next_done got done=%b dat=%h", if_done, if_dat);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_freeze;
        ld_req = 1'b1;
        ld_add = 32'h44;
        ld_len = 3'd4;
        tick();
        n_cmp++;
        if (ld_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL frz_gnt got %b want 1", ld_gnt);
        end
        en = 1'b0;
        mc_done = 1'b1;
        mc_rdat = 32'h55AA55AA;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({ld_gnt, ld_done} !== 2'b10) begin
                n_bad++;
                $display("FAIL frz_hold_%0d got gnt/done=%b want 10", i, {ld_gnt, ld_done});
            end
        end
        en = 1'b1;
        tick();
        mc_done = 1'b0;
        n_cmp++;
        if ({ld_gnt, ld_done} !== 2'b01 || ld_dat !== 32'h55AA55AA) begin
            n_bad++;
            $display("FAIL frz_done got gnt/done=%b dat=%h", {ld_gnt, ld_done}, ld_dat);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (ld_done !== 1'b1) begin
            n_bad++;
            $display("FAIL frz_extend got %b want 1", ld_done);
        end
        en = 1'b1;
        ld_req = 1'b0;
        tick();
        n_cmp++;
        if (ld_done !== 1'b0) begin
            n_bad++;
            $display("FAIL frz_release got %b want 0", ld_done);
        end
    endtask

    task automatic test_rst_busy;
        if_req = 1'b1;
        if_add = 32'h4000;
        st_req = 1'b1;
        st_add = 32'h100;
        st_len = 3'd1;
        st_dat = 32'hA5;
        tick();
        n_cmp++;
        if ({if_gnt, st_gnt} !== 2'b01) begin
            n_bad++;
            $display("FAIL rb_gnt got if/st=%b want 01", {if_gnt, st_gnt});
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_req = 1'b0;
        st_req = 1'b0;
        n_cmp++;
        if ({mc_en, st_gnt, mc_rw, mc_len, mc_add, mc_dat} !== '0) begin
            n_bad++;
            $display("FAIL rb_zero got en=%b rw=%b len=%0d add=%h", mc_en, mc_rw, mc_len, mc_add);
        end
        complete(32'h77);
        n_cmp++;
        if ({if_done, ld_done, st_done} !== 3'b000) begin
            n_bad++;
            $display("FAIL rb_late_done got %b want 000", {if_done, ld_done, st_done});
        end
    endtask

    task automatic test_age;
        logic [2:0] exp_g;
        if_req = 1'b1;
        if_add = 32'h5000;
        ld_req = 1'b1;
        ld_add = 32'h600;
        ld_len = 3'd4;
        st_req = 1'b1;
        st_add = 32'h700;
        st_len = 3'd2;
        st_dat = 32'h0;
        io_full = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_g = (k == AM + 1) ? 3'b100 : 3'b001;
            n_cmp++;
            if ({if_gnt, ld_gnt, st_gnt} !== exp_g || mc_en !== 1'b1) begin
                n_bad++;
                $display("FAIL age_grant_%0d got if/ld/st=%b en=%b want %b",
                    k, {if_gnt, ld_gnt, st_gnt}, mc_en, exp_g);
            end
            complete(32'(k));
            tick();
        end
        if_req = 1'b0;
        ld_req = 1'b0;
        st_req = 1'b0;
        tick();
    endtask

    task automatic test_random;
        logic ip, lp, sp, fe, se;
        logic [2:0] exp_g;
        logic [2:0] exp_len;
        logic [AW-1:0] exp_add;
        logic [DW-1:0] rd;
        int age;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        age = 0;
        ip = 1'b0;
        lp = 1'b0;
        sp = 1'b0;
        for (int r = 0; r < 80; r++) begin
            if (!ip && $urandom_range(1) == 1) begin
                ip = 1'b1;
                if_add = $urandom;
            end
            if (!lp && $urandom_range(1) == 1) begin
                lp = 1'b1;
                ld_add = $urandom;
                case ($urandom_range(2))
                    0: ld_len = 3'd1;
                    1: ld_len = 3'd2;
                    default: ld_len = 3'd4;
                endcase
            end
            if (!sp && $urandom_range(1) == 1) begin
                sp = 1'b1;
                st_add = $urandom;
                st_add[17:16] = ($urandom_range(2) == 0) ? 2'b11 : 2'b01;
                st_len = ($urandom_range(1) == 1) ? 3'd4 : 3'd1;
                st_dat = $urandom;
            end
            io_full = 1'($urandom_range(1));
            if_req = ip;
            ld_req = lp;
            st_req = sp;
            fe = ip;
            se = sp && !(st_add[17:16] == 2'b11 && io_full);
            exp_g = 3'b000;
            if (fe && age == AM) exp_g = 3'b100;
            else if (se) exp_g = 3'b001;
            else if (lp) exp_g = 3'b010;
            else if (fe) exp_g = 3'b100;
            exp_len = (exp_g == 3'b100) ? 3'd4 : (exp_g == 3'b010) ? ld_len : st_len;
            exp_add = (exp_g == 3'b100) ? if_add : (exp_g == 3'b010) ? ld_add : st_add;
            tick();
            n_cmp++;
            if ({if_gnt, ld_gnt, st_gnt} !== exp_g || mc_en !== (exp_g != 3'b000)) begin
                n_bad++;
                $display("FAIL rnd_gnt_%0d got if/ld/st=%b en=%b want %b",
                    r, {if_gnt, ld_gnt, st_gnt}, mc_en, exp_g);
            end
            if (exp_g != 3'b000) begin
                n_cmp++;
                if (mc_rw !== (exp_g == 3'b001) || mc_len !== exp_len || mc_add !== exp_add
                    || (exp_g == 3'b001 && mc_dat !== st_dat)) begin
                    n_bad++;
                    $display("FAIL rnd_cmd_%0d got rw=%b len=%0d add=%h dat=%h want len=%0d add=%h",
                        r, mc_rw, mc_len, mc_add, mc_dat, exp_len, exp_add);
                end
                if (exp_g == 3'b100) age = 0;
                else if (fe) age = (age >= AM) ? AM : age + 1;
                repeat ($urandom_range(3)) tick();
                rd = $urandom;
                complete(rd);
                n_cmp++;
                if ({if_done, ld_done, st_done} !== exp_g
                    || (exp_g == 3'b100 && if_dat !== rd)
                    || (exp_g == 3'b010 && ld_dat !== rd)) begin
                    n_bad++;
                    $display("FAIL rnd_done_%0d got if/ld/st=%b if_dat=%h ld_dat=%h want %b %h",
                        r, {if_done, ld_done, st_done}, if_dat, ld_dat, exp_g, rd);
                end
                if (exp_g == 3'b100) ip = 1'b0;
                if (exp_g == 3'b010) lp = 1'b0;
                if (exp_g == 3'b001) sp = 1'b0;
                if_req = ip;
                ld_req = lp;
                st_req = sp;
                tick();
            end
        end
        if_req = 1'b0;
        ld_req = 1'b0;
        st_req = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        en = 1'b1;
        clr = 1'b0;
        io_full = 1'b0;
        mc_done = 1'b0;
        mc_rdat = '0;
        if_req = 1'b0;
        ld_req = 1'b0;
        st_req = 1'b0;
        if_add = '0;
        ld_add = '0;
        st_add = '0;
        ld_len = 3'd0;
        st_len = 3'd0;
        st_dat = '0;
        test_reset();
        test_fetch();
        test_io_block();
        test_clr();
        test_freeze();
        test_rst_busy();
        test_age();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
